// File: rtl/mcu_fetch.sv
`default_nettype none
// ==== mcu_fetch : PC, in-order imem fetch, fetch queue toward decode, EX redirect ====
// ==== Revision 1.0 ====
module mcu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  localparam int            PW        = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int            CW        = $clog2(FQ_DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(FQ_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W   = (CW + 1)'(FQ_DEPTH);
  localparam logic [31:0]   NOP_INSTR = 32'h0000_0013;

  logic          started;
  logic          halted;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic [31:0]   q_pc    [FQ_DEPTH];
  logic [31:0]   q_instr [FQ_DEPTH];
  logic          q_fault [FQ_DEPTH];
  logic [PW-1:0] q_head;
  logic [PW-1:0] q_tail;
  logic [CW-1:0] q_count;

  logic [31:0]   af_addr [FQ_DEPTH];
  logic [PW-1:0] af_head;
  logic [PW-1:0] af_tail;

  logic          req_fire;
  logic          rsp_seen;
  logic          rsp_keep;
  logic          deq;
  logic          misaligned;
  logic [CW:0]   credit_used;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  // Credit counts both in-flight and buffered entries; same-cycle frees are not bypassed.
  assign credit_used    = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req_valid = started && !halted && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a leftover from before reset.
  assign rsp_seen   = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep   = rsp_seen && (drop_cnt == '0) && !redirect_valid;
  assign misaligned = (redirect_target[1:0] != 2'b00);

  assign if_valid = (q_count != '0);
  assign deq      = if_valid && if_ready;
  assign if_pc    = if_valid ? q_pc[q_head]    : 32'h0;
  assign if_instr = if_valid ? q_instr[q_head] : 32'h0;
  assign if_fault = if_valid ? q_fault[q_head] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      halted  <= 1'b0;
      pc      <= RESET_PC;
    end else begin
      started <= 1'b1;
      if (redirect_valid) begin
        if (misaligned) begin
          halted <= 1'b1;
        end else begin
          halted <= 1'b0;
          pc     <= redirect_target;
        end
      end else if (req_fire) begin
        pc <= pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_seen);
      if (redirect_valid) begin
        drop_cnt <= outstanding - CW'(rsp_seen);
      end else if (rsp_seen && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else if (redirect_valid) begin
      q_head <= '0;
      if (misaligned) begin
        q_tail  <= next_ptr('0);
        q_count <= CW'(1);
      end else begin
        q_tail  <= '0;
        q_count <= '0;
      end
    end else begin
      if (rsp_keep) q_tail <= next_ptr(q_tail);
      if (deq)      q_head <= next_ptr(q_head);
      q_count <= q_count + CW'(rsp_keep) - CW'(deq);
    end
  end

  // Payload storage needs no reset: outputs are gated by if_valid.
  always_ff @(posedge clk) begin
    if (redirect_valid) begin
      if (misaligned) begin
        q_pc[0]    <= redirect_target;
        q_instr[0] <= NOP_INSTR;
        q_fault[0] <= 1'b1;
      end
    end else if (rsp_keep) begin
      q_pc[q_tail]    <= af_addr[af_head];
      q_instr[q_tail] <= imem_rsp_data;
      q_fault[q_tail] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_head <= '0;
      af_tail <= '0;
    end else if (redirect_valid) begin
      af_head <= '0;
      af_tail <= '0;
    end else begin
      if (req_fire) af_tail <= next_ptr(af_tail);
      if (rsp_keep) af_head <= next_ptr(af_head);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) af_addr[af_tail] <= pc;
  end

endmodule
`default_nettype wire
